muldiv_ctrl: RTL and testbench

Sequencer for the HI/LO multiply/divide resource, including the architectural HI/LO registers. It accepts MULT/MULTU/DIV/DIVU from the execute stage and stalls the pipeline while a multi-cycle operation runs. It commits the 64-bit result to HI/LO and also services MTHI/MTLO writes arriving from write-back. It sits beside the execute-stage ALU and feeds `hi_o`/`lo_o` forward into the M/W pipeline registers.

---
 rtl/muldiv_ctrl_if.sv | 29 ++
 rtl/muldiv_ctrl.sv | 125 ++++++++++++
 tb/tb_muldiv_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_if.sv
// Execute/write-back side signals of the HI/LO multiply/divide sequencer.
`timescale 1ns/1ps
interface muldiv_ctrl_if;
  logic        mul_reqE;
  logic        div_reqE;
  logic        signedE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        flushE;
  logic        gprtohiW;
  logic        gprtoloW;
  logic [31:0] srcaW;
  logic        stallE;
  logic        busy;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output mul_reqE, div_reqE, signedE, srcaE, srcbE, flushE,
           gprtohiW, gprtoloW, srcaW,
    input  stallE, busy, hi_o, lo_o
  );

  modport slave (
    input  mul_reqE, div_reqE, signedE, srcaE, srcbE, flushE,
           gprtohiW, gprtoloW, srcaW,
    output stallE, busy, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: single-cycle multiply, 32-step restoring
// divide, architectural HI/LO with MTHI/MTLO writes.
//   state | meaning
//   IDLE  | waiting for MULT/DIV from E
//   MUL   | product computed, committed at end of cycle
//   DIV   | one quotient bit per cycle, cnt 0..31
//   DONE  | result visible, E released, request ignored
`timescale 1ns/1ps
module muldiv_ctrl (
  input logic         clk,
  input logic         rst,
  muldiv_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state;
  logic        busy_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] a_q, b_q;
  logic        sgn_q;
  logic [4:0]  cnt;
  logic [31:0] rem_q, qd_q, dvs_q;

  logic        accept;
  logic [63:0] ext_a, ext_b, prod;
  logic [32:0] trial;
  logic [31:0] r_nx, q_nx, q_fix, r_fix;

  function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
    return (s & x[31]) ? (~x + 32'd1) : x;
  endfunction

  assign accept = (bus.mul_reqE | bus.div_reqE) & ~bus.flushE;

  assign bus.stallE = rst & (((state == IDLE) & accept) |
                             (((state == MUL) | (state == DIV)) & ~bus.flushE));
  assign bus.busy   = busy_q;
  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;

  // Sign extension gated by signedness makes one 64-bit multiply serve both.
  assign ext_a = {{32{sgn_q & a_q[31]}}, a_q};
  assign ext_b = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod  = ext_a * ext_b;

  assign trial = {rem_q, qd_q[31]} - {1'b0, dvs_q};
  assign r_nx  = trial[32] ? {rem_q[30:0], qd_q[31]} : trial[31:0];
  assign q_nx  = {qd_q[30:0], ~trial[32]};
  assign q_fix = (sgn_q & (a_q[31] ^ b_q[31])) ? (~q_nx + 32'd1) : q_nx;
  assign r_fix = (sgn_q & a_q[31]) ? (~r_nx + 32'd1) : r_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
      cnt    <= '0;
      rem_q  <= '0;
      qd_q   <= '0;
      dvs_q  <= '0;
    end else begin
      // MTHI/MTLO first so a same-cycle MUL/DIV commit below overrides them.
      if (bus.gprtohiW) hi_q <= bus.srcaW;
      if (bus.gprtoloW) lo_q <= bus.srcaW;
      case (state)
        IDLE: begin
          if (accept) begin
            a_q    <= bus.srcaE;
            b_q    <= bus.srcbE;
            sgn_q  <= bus.signedE;
            cnt    <= '0;
            rem_q  <= '0;
            qd_q   <= mag(bus.srcaE, bus.signedE);
            dvs_q  <= mag(bus.srcbE, bus.signedE);
            state  <= bus.mul_reqE ? MUL : DIV;
            busy_q <= 1'b1;
          end
        end
        MUL: begin
          if (bus.flushE) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            {hi_q, lo_q} <= prod;
            state        <= DONE;
          end
        end
        DIV: begin
          if (bus.flushE) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            rem_q <= r_nx;
            qd_q  <= q_nx;
            cnt   <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state <= DONE;
              if (b_q == 32'd0) begin
                lo_q <= 32'hFFFF_FFFF;
                hi_q <= a_q;
              end else begin
                lo_q <= q_fix;
                hi_q <= r_fix;
              end
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases plus randomized ops
// against a plain-arithmetic HI/LO model.
`timescale 1ns/1ps
module tb_muldiv_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  muldiv_ctrl_if bus ();

  muldiv_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {hi, lo} from the architectural definition of MULT/MULTU/DIV/DIVU.
  function automatic logic [63:0] ref_res(input bit isdiv, input bit sgn,
                                          input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (!isdiv) begin
      p = 64'(sa * sb);
      return p;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic run_op(input bit isdiv, input bit sgn, input logic [31:0] a,
                        input logic [31:0] b, input bit mthi_mid, input string tag);
    logic [63:0] r;
    int n;
    r = ref_res(isdiv, sgn, a, b);
    @(negedge clk);
    bus.mul_reqE = !isdiv;
    bus.div_reqE = isdiv;
    bus.signedE  = sgn;
    bus.srcaE    = a;
    bus.srcbE    = b;
    #1;
    n = 0;
    while (bus.stallE === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      bus.gprtohiW = mthi_mid && (n == 5);
      bus.srcaW    = 32'hDEAD_BEEF;
      #1;
    end
    bus.gprtohiW = 1'b0;
    chk({tag, " stall_cycles"}, 64'(n), isdiv ? 64'd33 : 64'd2);
    chk({tag, " hi"}, 64'(bus.hi_o), 64'(r[63:32]));
    chk({tag, " lo"}, 64'(bus.lo_o), 64'(r[31:0]));
    chk({tag, " busy_done"}, 64'(bus.busy), 64'd1);
    bus.mul_reqE = 1'b0;
    bus.div_reqE = 1'b0;
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    @(negedge clk);
    #1;
    chk({tag, " idle_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, " idle_stall"}, 64'(bus.stallE), 64'd0);
  endtask

  initial begin
    logic [31:0] a, b, v;
    bit isdiv, sgn;
    int sel;

    bus.mul_reqE = 0; bus.div_reqE = 0; bus.signedE = 0;
    bus.srcaE = '0; bus.srcbE = '0; bus.flushE = 0;
    bus.gprtohiW = 0; bus.gprtoloW = 0; bus.srcaW = '0;

    #1;
    chk("reset hi", 64'(bus.hi_o), 64'd0);
    chk("reset lo", 64'(bus.lo_o), 64'd0);
    chk("reset stall", 64'(bus.stallE), 64'd0);
    chk("reset busy", 64'(bus.busy), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_op(0, 1, 32'hFFFF_FFFE, 32'h0000_0003, 0, "mult_s");
    chk("mult_s const", {exp_hi, exp_lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(0, 0, 32'hFFFF_FFFE, 32'h0000_0003, 0, "multu");
    chk("multu const", {exp_hi, exp_lo}, 64'h0000_0002_FFFF_FFFA);
    run_op(1, 1, 32'hFFFF_FFF9, 32'd2, 0, "div_s_m7_2");
    chk("div_s const", {exp_hi, exp_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(1, 0, 32'd100, 32'd7, 0, "divu_100_7");
    chk("divu const", {exp_hi, exp_lo}, {32'd2, 32'd14});
    run_op(1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    chk("div_ovf const", {exp_hi, exp_lo}, 64'h0000_0000_8000_0000);
    run_op(1, 0, 32'd5, 32'd0, 0, "divu_by0");
    chk("div_by0 const", {exp_hi, exp_lo}, {32'd5, 32'hFFFF_FFFF});
    run_op(1, 1, 32'hFFFF_FFF0, 32'd0, 0, "div_s_by0");
    run_op(1, 0, 32'd1000, 32'd9, 1, "div_mthi_inflight");

    // Flush at DIV iteration 10: HI/LO keep their prior values.
    @(negedge clk);
    bus.div_reqE = 1; bus.signedE = 0; bus.srcaE = 32'd12345; bus.srcbE = 32'd17;
    #1;
    chk("flush accept stall", 64'(bus.stallE), 64'd1);
    repeat (11) @(negedge clk);
    bus.flushE = 1;
    #1;
    chk("flush cycle stall", 64'(bus.stallE), 64'd0);
    chk("flush cycle busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    bus.div_reqE = 0; bus.flushE = 0;
    #1;
    chk("flush busy", 64'(bus.busy), 64'd0);
    chk("flush hi", 64'(bus.hi_o), 64'(exp_hi));
    chk("flush lo", 64'(bus.lo_o), 64'(exp_lo));
    repeat (40) @(negedge clk);
    #1;
    chk("flush late hi", 64'(bus.hi_o), 64'(exp_hi));
    chk("flush late lo", 64'(bus.lo_o), 64'(exp_lo));

    // Request killed in IDLE is not accepted.
    @(negedge clk);
    bus.mul_reqE = 1; bus.flushE = 1;
    #1;
    chk("idle flush stall", 64'(bus.stallE), 64'd0);
    @(negedge clk);
    bus.mul_reqE = 0; bus.flushE = 0;
    #1;
    chk("idle flush busy", 64'(bus.busy), 64'd0);

    // MTHI coincident with MUL commit: commit wins.
    @(negedge clk);
    bus.mul_reqE = 1; bus.signedE = 0; bus.srcaE = 32'd2; bus.srcbE = 32'd3;
    @(negedge clk);
    bus.gprtohiW = 1; bus.srcaW = 32'h1234_5678;
    @(negedge clk);
    bus.gprtohiW = 0; bus.mul_reqE = 0;
    #1;
    chk("conflict hi", 64'(bus.hi_o), 64'd0);
    chk("conflict lo", 64'(bus.lo_o), 64'd6);
    exp_hi = 32'd0; exp_lo = 32'd6;

    // MTLO alone in IDLE.
    v = $urandom;
    @(negedge clk);
    bus.gprtoloW = 1; bus.srcaW = v;
    @(negedge clk);
    bus.gprtoloW = 0;
    #1;
    chk("mtlo lo", 64'(bus.lo_o), 64'(v));
    chk("mtlo hi", 64'(bus.hi_o), 64'(exp_hi));
    exp_lo = v;

    for (int i = 0; i < 16; i++) begin
      isdiv = 1'($urandom_range(0, 1));
      sgn   = 1'($urandom_range(0, 1));
      a     = $urandom;
      sel   = $urandom_range(0, 7);
      case (sel)
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op(isdiv, sgn, a, b, 0, $sformatf("rand%0d", i));
    end

    // Reset mid-DIV drops everything immediately.
    @(negedge clk);
    bus.div_reqE = 1; bus.signedE = 0; bus.srcaE = 32'd1000; bus.srcbE = 32'd3;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst hi", 64'(bus.hi_o), 64'd0);
    chk("midrst lo", 64'(bus.lo_o), 64'd0);
    chk("midrst stall", 64'(bus.stallE), 64'd0);
    chk("midrst busy", 64'(bus.busy), 64'd0);
    bus.div_reqE = 0;
    @(negedge clk);
    rst = 1'b1;
    exp_hi = '0; exp_lo = '0;
    run_op(0, 1, 32'h8000_0000, 32'h8000_0000, 0, "post_rst_mult");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
